seq_divider: RTL

Sequential restoring divider that computes quotient and remainder of two 16-bit operands, one quotient bit per clock. It is the inverse of the combinational shift-add multiplier in the ALU breadboard. It replaces the single-cycle divide and modulo channels with a start/done handshake, so the datapath no longer carries a combinational divider. Results are widened to 32 bits so they drop straight into the existing 32-bit result mux channels.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 30 +++
 rtl/seq_divider.sv | 128 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH     = 16;
  localparam int unsigned DIV_OUT_WIDTH = 32;
  localparam int unsigned DIV_CNT_W     = $clog2(DIV_WIDTH + 1);

  localparam logic [DIV_OUT_WIDTH-1:0] DIV_ZERO_RESULT = '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract, restore on borrow.
module div_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  localparam int unsigned RemW = WIDTH + 1;

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  always_comb begin
    rem_sh = RemW'({rem_i, quo_i[WIDTH-1]});
    trial  = rem_sh - {1'b0, div_i};
    // The MSB of the trial result is the borrow: set means the divisor did not fit.
    if (trial[WIDTH]) begin
      rem_o = rem_sh;
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = trial;
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider with start/done handshake, one quotient bit per clock.
// Optional SIGNED_DIV_EN: two's-complement operands, truncating division, sign-extended results.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH     = DIV_WIDTH,
  parameter int unsigned OUT_WIDTH = DIV_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     inputA,
  input  logic [WIDTH-1:0]     inputB,
  output logic                 busy,
  output logic                 done,
  output logic [OUT_WIDTH-1:0] resDiv,
  output logic [OUT_WIDTH-1:0] resMod,
  output logic                 divZero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvs_q;
  logic               zero_q;
  logic [WIDTH:0]     rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [OUT_WIDTH-1:0] div_res;
  logic [OUT_WIDTH-1:0] mod_res;

`ifdef SIGNED_DIV_EN
  logic a_neg;
  logic b_neg;
  logic q_neg_q;
  logic r_neg_q;

  assign a_neg = inputA[WIDTH-1];
  assign b_neg = inputB[WIDTH-1];
  assign a_mag = a_neg ? WIDTH'(-inputA) : inputA;
  assign b_mag = b_neg ? WIDTH'(-inputB) : inputB;
`else
  assign a_mag = inputA;
  assign b_mag = inputB;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (dvs_q),
    .rem_o (rem_d),
    .quo_o (quo_d)
  );

  // Final results, widened first so that a negated 2^(WIDTH-1) magnitude stays positive.
  always_comb begin
    div_res = OUT_WIDTH'(quo_q);
    mod_res = OUT_WIDTH'(rem_q[WIDTH-1:0]);
`ifdef SIGNED_DIV_EN
    if (q_neg_q) div_res = -div_res;
    if (r_neg_q) mod_res = -mod_res;
`endif
  end

  // A zero divisor takes one pass through CALC with count 0, so done lands after edge 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      resDiv  <= '0;
      resMod  <= '0;
      divZero <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      zero_q  <= 1'b0;
`ifdef SIGNED_DIV_EN
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= CALC;
            busy    <= 1'b1;
            divZero <= 1'b0;
            rem_q   <= '0;
            quo_q   <= a_mag;
            dvs_q   <= b_mag;
            zero_q  <= (inputB == '0);
            cnt_q   <= (inputB == '0) ? '0 : CntW'(WIDTH);
`ifdef SIGNED_DIV_EN
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
`endif
          end
        end
        CALC: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            divZero <= zero_q;
            resDiv  <= zero_q ? '1 : div_res;
            resMod  <= zero_q ? '1 : mod_res;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
